ring_inject_scheduler: RTL and testbench

//  Per-node injection scheduler between local packet sources and the PE input

---
 rtl/ring_inject_scheduler.sv | 114 +++++++++++
 tb/tb_ring_inject_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_inject_scheduler.sv
// ring_inject_scheduler
//   Per-node injection scheduler feeding the PE input port of one gold_ring
//   router. Generates the global ring polarity, arbitrates NUM_SRC local
//   sources round-robin per virtual channel, and holds one packet per VC that
//   is offered to the router only in cycles whose polarity equals its VC bit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   src_valid  per-source packet-present flags
//   src_data   packed source packets, slice i = [i*DW +: DW], bit 0 = VC
//   src_ack    one-hot-per-VC capture pulse (combinational, up to 2 bits set)
//   pe_ri      router PE input ready
//   pe_so      send strobe to router PE input
//   pe_do      packet to router PE input (zero when not sending)
//   polarity   global ring polarity, toggles every cycle out of reset
//   pkt_count  total packets injected, wraps
module ring_inject_scheduler #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DW      = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*DW-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic                  pe_ri,
  output logic                  pe_so,
  output logic [DW-1:0]         pe_do,
  output logic                  polarity,
  output logic [CNT_W-1:0]      pkt_count
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } vc_state_t;

  vc_state_t        vc_state [2];
  logic [DW-1:0]    buf_data [2];
  logic [PTR_W-1:0] rr_ptr   [2];

  logic             gnt_vld  [2];
  logic [PTR_W-1:0] gnt_idx  [2];
  logic [DW-1:0]    gnt_data [2];
  logic             drain;

  // Injection side: the buffer selected by the current polarity is offered.
  assign pe_so = (vc_state[polarity] == FULL);
  assign pe_do = pe_so ? buf_data[polarity] : '0;
  assign drain = pe_so & pe_ri;

  // Per-VC round-robin grant. Only buffers empty at cycle start may grant, so
  // a buffer that drains this cycle cannot also capture in this cycle.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned v = 0; v < 2; v++) begin
      gnt_vld[v]  = 1'b0;
      gnt_idx[v]  = '0;
      gnt_data[v] = '0;
      if (vc_state[v] == EMPTY) begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
          idx = 32'(rr_ptr[v]) + k;
          if (idx >= NUM_SRC) idx = idx - NUM_SRC;
          if (!gnt_vld[v] && src_valid[idx] && (src_data[idx*DW] == v[0])) begin
            gnt_vld[v]  = 1'b1;
            gnt_idx[v]  = idx[PTR_W-1:0];
            gnt_data[v] = src_data[idx*DW +: DW];
          end
        end
      end
    end
  end

  // Acks are forced low while reset is held, since the grant logic alone would
  // see empty buffers and grant.
  always_comb begin
    src_ack = '0;
    if (reset) begin
      for (int unsigned v = 0; v < 2; v++) begin
        if (gnt_vld[v]) src_ack[gnt_idx[v]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity  <= 1'b0;
      pkt_count <= '0;
      for (int unsigned v = 0; v < 2; v++) begin
        vc_state[v] <= EMPTY;
        buf_data[v] <= '0;
        rr_ptr[v]   <= '0;
      end
    end else begin
      polarity <= ~polarity;
      if (drain) pkt_count <= pkt_count + 1'b1;
      for (int unsigned v = 0; v < 2; v++) begin
        if (vc_state[v] == FULL) begin
          if (drain && (polarity == v[0])) vc_state[v] <= EMPTY;
        end else if (gnt_vld[v]) begin
          vc_state[v] <= FULL;
          buf_data[v] <= gnt_data[v];
          rr_ptr[v]   <= (gnt_idx[v] == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx[v] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_inject_scheduler.sv
// Directed bench for ring_inject_scheduler. A second, narrow instance with a
// 4-bit counter exercises the counter wrap in a few dozen cycles.
module tb_ring_inject_scheduler;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    src_valid = '0;
  logic [127:0]  src_data = '0;
  logic [1:0]    src_ack;
  logic          pe_ri = 1'b0;
  logic          pe_so;
  logic [63:0]   pe_do;
  logic          polarity;
  logic [15:0]   pkt_count;

  logic [1:0]    w_valid = '0;
  logic [15:0]   w_data = '0;
  logic [1:0]    w_ack;
  logic          w_ri = 1'b0;
  logic          w_so;
  logic [7:0]    w_do;
  logic          w_pol;
  logic [3:0]    w_count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_inj    = 0;
  logic exp_pol = 1'b0;

  ring_inject_scheduler #(.NUM_SRC(2), .DW(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ack(src_ack), .pe_ri(pe_ri), .pe_so(pe_so), .pe_do(pe_do),
    .polarity(polarity), .pkt_count(pkt_count)
  );

  ring_inject_scheduler #(.NUM_SRC(2), .DW(8), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .src_valid(w_valid), .src_data(w_data),
    .src_ack(w_ack), .pe_ri(w_ri), .pe_so(w_so), .pe_do(w_do),
    .polarity(w_pol), .pkt_count(w_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    exp_pol = ~exp_pol;
  endtask

  task automatic align(input logic p);
    for (int i = 0; i < 2 && exp_pol != p; i++) tick();
  endtask

  initial begin
    #2;
    n_assert++; if (polarity !== 1'b0) begin n_fail++; $error("FAIL rst_pol %0h", polarity); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL rst_so %0h", pe_so); end
    n_assert++; if (pe_do !== 64'h0) begin n_fail++; $error("FAIL rst_do %0h", pe_do); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL rst_ack %0h", src_ack); end
    n_assert++; if (pkt_count !== 16'h0) begin n_fail++; $error("FAIL rst_cnt %0h", pkt_count); end
    #10 reset = 1'b1;
    exp_pol = 1'b0;
    tick();
    n_assert++; if (polarity !== 1'b1) begin n_fail++; $error("FAIL pol_rel1 %0h", polarity); end
    tick();
    n_assert++; if (polarity !== 1'b0) begin n_fail++; $error("FAIL pol_rel2 %0h", polarity); end

    // T2: single VC0 packet
    align(1'b1);
    src_data[63:0] = 64'hAAAA; src_valid = 2'b01; pe_ri = 1'b1; #1;
    n_assert++; if (src_ack !== 2'b01) begin n_fail++; $error("FAIL t2_ack %0h", src_ack); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t2_so_pre %0h", pe_so); end
    tick(); src_valid = '0; #1;
    n_assert++; if (polarity !== exp_pol) begin n_fail++; $error("FAIL t2_pol %0h", polarity); end
    n_assert++; if (pe_so !== 1'b1) begin n_fail++; $error("FAIL t2_so %0h", pe_so); end
    n_assert++; if (pe_do !== 64'hAAAA) begin n_fail++; $error("FAIL t2_do %0h", pe_do); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t2_ack_idle %0h", src_ack); end
    tick();
    n_assert++; if (pkt_count !== 16'd1) begin n_fail++; $error("FAIL t2_cnt %0h", pkt_count); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t2_so_off %0h", pe_so); end

    // T3: two VC1 sources contend, round-robin order
    src_data = {64'h2223, 64'h1111}; src_valid = 2'b11; #1;
    n_assert++; if (src_ack !== 2'b01) begin n_fail++; $error("FAIL t3_ack_a %0h", src_ack); end
    tick(); src_valid = 2'b10; #1;
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t3_ack_full %0h", src_ack); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t3_so_p0 %0h", pe_so); end
    tick();
    n_assert++; if (pe_so !== 1'b1) begin n_fail++; $error("FAIL t3_so_a %0h", pe_so); end
    n_assert++; if (pe_do !== 64'h1111) begin n_fail++; $error("FAIL t3_do_a %0h", pe_do); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t3_ack_full2 %0h", src_ack); end
    tick();
    n_assert++; if (pkt_count !== 16'd2) begin n_fail++; $error("FAIL t3_cnt_a %0h", pkt_count); end
    n_assert++; if (src_ack !== 2'b10) begin n_fail++; $error("FAIL t3_ack_b %0h", src_ack); end
    tick(); src_valid = '0; #1;
    n_assert++; if (pe_do !== 64'h2223) begin n_fail++; $error("FAIL t3_do_b %0h", pe_do); end
    tick();
    n_assert++; if (pkt_count !== 16'd3) begin n_fail++; $error("FAIL t3_cnt_b %0h", pkt_count); end
    src_data = {64'h4445, 64'h3333}; src_valid = 2'b11; #1;
    n_assert++; if (src_ack !== 2'b01) begin n_fail++; $error("FAIL t3_ack_c %0h", src_ack); end
    tick(); src_valid = 2'b10; #1;
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t3_ack_full3 %0h", src_ack); end
    n_assert++; if (pe_do !== 64'h3333) begin n_fail++; $error("FAIL t3_do_c %0h", pe_do); end
    tick();
    n_assert++; if (src_ack !== 2'b10) begin n_fail++; $error("FAIL t3_ack_d %0h", src_ack); end
    n_assert++; if (pkt_count !== 16'd4) begin n_fail++; $error("FAIL t3_cnt_c %0h", pkt_count); end
    tick(); src_valid = '0; #1;
    n_assert++; if (pe_do !== 64'h4445) begin n_fail++; $error("FAIL t3_do_d %0h", pe_do); end
    tick();
    n_assert++; if (pkt_count !== 16'd5) begin n_fail++; $error("FAIL t3_cnt_d %0h", pkt_count); end

    // T4: router back-pressure holds buf[0]
    src_data[63:0] = 64'h5550; src_valid = 2'b01; pe_ri = 1'b0; #1;
    n_assert++; if (src_ack !== 2'b01) begin n_fail++; $error("FAIL t4_ack_a %0h", src_ack); end
    tick(); src_data[127:64] = 64'h6666; src_valid = 2'b10; #1;
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t4_ack_hold %0h", src_ack); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t4_so_p1 %0h", pe_so); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_assert++; if (pe_so !== ~exp_pol) begin n_fail++; $error("FAIL t4_so_stall %0h", pe_so); end
      n_assert++; if (pe_do !== (exp_pol ? 64'h0 : 64'h5550)) begin n_fail++; $error("FAIL t4_do_stall %0h", pe_do); end
      n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t4_ack_stall %0h", src_ack); end
    end
    n_assert++; if (pkt_count !== 16'd5) begin n_fail++; $error("FAIL t4_cnt_hold %0h", pkt_count); end
    pe_ri = 1'b1;
    tick();
    n_assert++; if (pe_so !== 1'b1) begin n_fail++; $error("FAIL t4_so_go %0h", pe_so); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t4_ack_drain %0h", src_ack); end
    tick();
    n_assert++; if (pkt_count !== 16'd6) begin n_fail++; $error("FAIL t4_cnt %0h", pkt_count); end
    n_assert++; if (src_ack !== 2'b10) begin n_fail++; $error("FAIL t4_ack_b %0h", src_ack); end
    tick(); src_valid = '0; #1;
    n_assert++; if (pe_do !== 64'h6666) begin n_fail++; $error("FAIL t4_do_b %0h", pe_do); end
    tick();
    n_assert++; if (pkt_count !== 16'd7) begin n_fail++; $error("FAIL t4_cnt_b %0h", pkt_count); end

    // T5: both VCs captured in the same cycle
    src_data = {64'h8881, 64'h7770}; src_valid = 2'b11; #1;
    n_assert++; if (src_ack !== 2'b11) begin n_fail++; $error("FAIL t5_ack %0h", src_ack); end
    tick(); src_valid = '0; #1;
    n_assert++; if (pe_do !== 64'h7770) begin n_fail++; $error("FAIL t5_do0 %0h", pe_do); end
    tick();
    n_assert++; if (pkt_count !== 16'd8) begin n_fail++; $error("FAIL t5_cnt1 %0h", pkt_count); end
    n_assert++; if (pe_do !== 64'h8881) begin n_fail++; $error("FAIL t5_do1 %0h", pe_do); end
    tick();
    n_assert++; if (pkt_count !== 16'd9) begin n_fail++; $error("FAIL t5_cnt2 %0h", pkt_count); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t5_so_off %0h", pe_so); end

    // T1: asynchronous reset with both buffers full
    src_data = {64'h9991, 64'h9990}; src_valid = 2'b11; #1;
    n_assert++; if (src_ack !== 2'b11) begin n_fail++; $error("FAIL t1_ack %0h", src_ack); end
    tick(); src_data[63:0] = 64'hBBB1; src_valid = 2'b01; #1;
    n_assert++; if (pe_so !== 1'b1) begin n_fail++; $error("FAIL t1_so_pre %0h", pe_so); end
    n_assert++; if (pe_do !== 64'h9991) begin n_fail++; $error("FAIL t1_do_pre %0h", pe_do); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t1_ack_pre %0h", src_ack); end
    reset = 1'b0; exp_pol = 1'b0; #1;
    n_assert++; if (polarity !== 1'b0) begin n_fail++; $error("FAIL t1_pol %0h", polarity); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t1_so %0h", pe_so); end
    n_assert++; if (pe_do !== 64'h0) begin n_fail++; $error("FAIL t1_do %0h", pe_do); end
    n_assert++; if (src_ack !== 2'b00) begin n_fail++; $error("FAIL t1_ack_rst %0h", src_ack); end
    n_assert++; if (pkt_count !== 16'h0) begin n_fail++; $error("FAIL t1_cnt %0h", pkt_count); end
    src_valid = '0; #1 reset = 1'b1;
    tick();
    n_assert++; if (polarity !== 1'b1) begin n_fail++; $error("FAIL t1_pol_a %0h", polarity); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t1_so_a %0h", pe_so); end
    tick();
    n_assert++; if (polarity !== 1'b0) begin n_fail++; $error("FAIL t1_pol_b %0h", polarity); end
    n_assert++; if (pe_so !== 1'b0) begin n_fail++; $error("FAIL t1_so_b %0h", pe_so); end
    n_assert++; if (pkt_count !== 16'h0) begin n_fail++; $error("FAIL t1_cnt_b %0h", pkt_count); end

    // T6: counter wrap on the 4-bit instance, both VCs streaming
    w_data = {8'h03, 8'h02}; w_valid = 2'b11; w_ri = 1'b1; #1;
    n_assert++; if (w_ack !== 2'b11) begin n_fail++; $error("FAIL t6_ack %0h", w_ack); end
    tick();
    n_assert++; if (w_do !== (exp_pol ? 8'h03 : 8'h02)) begin n_fail++; $error("FAIL t6_do %0h", w_do); end
    n_inj = 0;
    for (int i = 0; i < 200 && n_inj < 15; i++) begin
      if (w_so) n_inj++;
      tick();
    end
    n_assert++; if (n_inj !== 15) begin n_fail++; $error("FAIL t6_bound_a %0d", n_inj); end
    n_assert++; if (w_count !== 4'hF) begin n_fail++; $error("FAIL t6_cnt_max %0h", w_count); end
    for (int i = 0; i < 20 && n_inj < 16; i++) begin
      if (w_so) n_inj++;
      tick();
    end
    n_assert++; if (n_inj !== 16) begin n_fail++; $error("FAIL t6_bound_b %0d", n_inj); end
    n_assert++; if (w_count !== 4'h0) begin n_fail++; $error("FAIL t6_cnt_wrap %0h", w_count); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
